xnor_based_carry_lookahead_adder16_xor_enc32: RTL and testbench
===============================================================

# xnor_based_carry_lookahead_adder16_xor_enc32

16-bit carry-lookahead adder protected by logic locking with 32 XOR/XNOR key gates, and a registered 17-bit sum output. With the correct 32-bit key (32'h094F5C00) it produces `add1_i + add2_i`. Any other key deterministically corrupts internal propagate/generate nets. It sits in the locked-netlist evaluation suite as the 16-bit CLA benchmark for key-correctness checks.

## Interface
- Clock: single clock `clk`; reset `rst_n` is asynchronous and active-low.
- No parameters; widths are fixed at 16 bits of data and 32 bits of key.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  async active-low reset
- `add1_i`  in  16  operand A
- `add2_i`  in  16  operand B
- `keyinput`  in  32  locking key; correct value 32'h094F5C00
- `result_o`  out  17  registered sum; bit 16 is carry-out

## Operation
- Per bit i (0..15):
  - raw `p_i = a_i ^ b_i`
  - raw `g_i = a_i & b_i`
- Key gates: 32 gates, each on its own net.
  - `keyinput[i]` locks `p_i`.
  - `keyinput[16+i]` locks `g_i`.
  - Gate type follows bit j of the polarity mask M = 32'h094F5C00: XNOR where M[j]=1, XOR where M[j]=0.
  - Net effect: `locked = raw ^ keyinput[j] ^ M[j]`.
  - Set mask bits are 10, 11, 12, 14, 16, 17, 18, 19, 22, 24, 27.
- Carry-in is 0.
- Carries use the locked p/g and are computed by lookahead:
  - Four 4-bit CLA groups; each produces group P and G.
  - A second-level lookahead unit computes c4, c8, c12, c16.
  - Intra-group carries are computed in lookahead form, not rippled.
- Function: `c_{i+1} = g_i | (p_i & c_i)` and `s_i = p_i ^ c_i`, both using the locked p/g.
- `result_o` = {c16, s15..s0}. With the correct key this equals the zero-extended sum of the two operands.
- Wrong-key behaviour is fully defined by the equations above. No X outputs and no error flag.

## Timing
- All inputs, including the key, feed the combinational datapath.
- `result_o` is registered on the rising edge of `clk`; latency is 1 cycle.
- New operands may be applied every cycle; throughput is 1 result per cycle.
- Reset: `result_o` = 17'h00000 immediately on `rst_n` low, independent of `clk`. It holds that value until the first rising edge after `rst_n` deasserts.
- Reset asserted mid-stream discards the in-flight result. There is no other state.
- A key change takes effect on the next captured result. The key is not latched separately.
- Overflow: 16'hFFFF + 16'hFFFF gives 17'h1FFFE. There is no wrap-around; bit 16 always carries out.

## Structure
- Package `xcla_lock_pkg`:
  - `KEY_W` = 32
  - `DATA_W` = 16
  - `KEY_POLARITY` = 32'h094F5C00 (the gate-type mask)
- Sub-module `cla4`:
  - Inputs: 4-bit locked p and g, plus carry-in.
  - Outputs: 4 sum bits, group P, group G.
  - Instantiated 4 times.
- The top level contains:
  - p/g generation
  - the 32 key gates, one explicit XOR or XNOR per net, so they are visible in the netlist
  - the second-level lookahead
  - the output register

## Test plan
- Reset: hold `rst_n`=0 with any operands -> `result_o`=17'h00000; release -> first edge captures the sum.
- Correct key, directed sums (each checked 1 cycle after apply):
  - 29AF+7A1B -> 0A3CA
  - 5555+AAAA -> 0FFFF
  - 1024+8192 -> 091B6
  - 0000+0000 -> 00000
- Correct key, carry-out cases:
  - 8943+FFFF -> 18942
  - 8051+8086 -> 100D7
  - FFFF+FFFF -> 1FFFE
- Back-to-back: apply FADC+00DC, then 4096+2048, on consecutive cycles -> 0FBB8 then 060DE on consecutive cycles.
- Wrong key: key=32'h00000000, operands 0000+0000 -> 06E9E. Flipping any single key bit on random operands must change the result for some vector.
- Random: 10k random operand pairs with the correct key -> `result_o` == a+b; reset asserted asynchronously mid-run -> immediate zero.

Source files
------------

// File: rtl/xcla_lock_pkg.sv
// xcla_lock_pkg: widths and key-gate polarity mask for the locked 16-bit CLA
package xcla_lock_pkg;
    localparam int KEY_W = 32;
    localparam int DATA_W = 16;
    localparam logic [KEY_W-1:0] KEY_POLARITY = 32'h094F5C00;
endpackage

// File: rtl/cla4.sv
// cla4: 4-bit lookahead group producing sum bits and group propagate/generate
module cla4 (
    input  logic [3:0] p,
    input  logic [3:0] g,
    input  logic       ci,
    output logic [3:0] s,
    output logic       gp,
    output logic       gg
);
    logic [3:0] c;
    always_comb begin
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        s = p ^ c;
        gp = &p;
        gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    end
endmodule

// File: rtl/xnor_based_carry_lookahead_adder16_xor_enc32.sv
// xnor_based_carry_lookahead_adder16_xor_enc32: key-locked 16-bit CLA with registered 17-bit sum
module xnor_based_carry_lookahead_adder16_xor_enc32
    import xcla_lock_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] add1_i,
    input  logic [DATA_W-1:0] add2_i,
    input  logic [KEY_W-1:0]  keyinput,
    output logic [DATA_W:0]   result_o
);
    logic [DATA_W-1:0] p_raw, g_raw, p, g, s;
    logic [3:0] gp, gg;
    logic [4:0] c;

    assign p_raw = add1_i ^ add2_i;
    assign g_raw = add1_i & add2_i;

    // One discrete gate per locked net so every key bit stays visible in the netlist
    for (genvar i = 0; i < DATA_W; i++) begin : g_key
        if (KEY_POLARITY[i]) begin : g_pxn
            assign p[i] = p_raw[i] ~^ keyinput[i];
        end else begin : g_px
            assign p[i] = p_raw[i] ^ keyinput[i];
        end
        if (KEY_POLARITY[DATA_W+i]) begin : g_gxn
            assign g[i] = g_raw[i] ~^ keyinput[DATA_W+i];
        end else begin : g_gx
            assign g[i] = g_raw[i] ^ keyinput[DATA_W+i];
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_grp
        cla4 u_cla4 (
            .p  (p[4*i +: 4]),
            .g  (g[4*i +: 4]),
            .ci (c[i]),
            .s  (s[4*i +: 4]),
            .gp (gp[i]),
            .gg (gg[i])
        );
    end

    always_comb begin
        c[0] = 1'b0;
        c[1] = gg[0] | (gp[0] & c[0]);
        c[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c[0]);
        c[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) | (gp[2] & gp[1] & gp[0] & c[0]);
        c[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) | (gp[3] & gp[2] & gp[1] & gg[0])
             | (gp[3] & gp[2] & gp[1] & gp[0] & c[0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) result_o <= '0;
        else result_o <= {c[4], s};
    end
endmodule

// File: tb/tb_xnor_based_carry_lookahead_adder16_xor_enc32.sv
// tb_xnor_based_carry_lookahead_adder16_xor_enc32: directed and random checks against a bit-serial reference
module tb_xnor_based_carry_lookahead_adder16_xor_enc32;
    localparam logic [31:0] KEY = 32'h094F5C00;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] add1_i = '0;
    logic [15:0] add2_i = '0;
    logic [31:0] keyinput = KEY;
    logic [16:0] result_o;
    int checks = 0;
    int errors = 0;

    xnor_based_carry_lookahead_adder16_xor_enc32 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .add1_i   (add1_i),
        .add2_i   (add2_i),
        .keyinput (keyinput),
        .result_o (result_o)
    );

    always #5 clk = ~clk;

    // Locked p/g per the key equations, carries resolved bit by bit
    function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b, input logic [31:0] k);
        logic [15:0] lp, lg, sum;
        logic cy;
        logic [31:0] m;
        m = KEY;
        lp = (a ^ b) ^ k[15:0] ^ m[15:0];
        lg = (a & b) ^ k[31:16] ^ m[31:16];
        cy = 1'b0;
        for (int i = 0; i < 16; i++) begin
            sum[i] = lp[i] ^ cy;
            cy = lg[i] | (lp[i] & cy);
        end
        return {cy, sum};
    endfunction

    task automatic check(input string tag, input logic [16:0] exp);
        checks++;
        assert (result_o === exp) else begin
            errors++;
            $error("FAIL %s got %h expected %h", tag, result_o, exp);
        end
    endtask

    task automatic step(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] k, input logic [16:0] exp);
        @(negedge clk);
        add1_i = a;
        add2_i = b;
        keyinput = k;
        @(posedge clk);
        #1 check(tag, exp);
    endtask

    initial begin
        logic [15:0] a, b;
        logic [31:0] k;
        add1_i = 16'h29AF;
        add2_i = 16'h7A1B;
        #3 check("reset_async", 17'h00000);
        @(posedge clk);
        #1 check("reset_hold", 17'h00000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("first_capture", 17'h0A3CA);

        step("d_29AF_7A1B", 16'h29AF, 16'h7A1B, KEY, 17'h0A3CA);
        step("d_5555_AAAA", 16'h5555, 16'hAAAA, KEY, 17'h0FFFF);
        step("d_1024_8192", 16'h1024, 16'h8192, KEY, 17'h091B6);
        step("d_0000_0000", 16'h0000, 16'h0000, KEY, 17'h00000);
        step("co_8943_FFFF", 16'h8943, 16'hFFFF, KEY, 17'h18942);
        step("co_8051_8086", 16'h8051, 16'h8086, KEY, 17'h100D7);
        step("co_FFFF_FFFF", 16'hFFFF, 16'hFFFF, KEY, 17'h1FFFE);
        step("b2b_first", 16'hFADC, 16'h00DC, KEY, 17'h0FBB8);
        step("b2b_second", 16'h4096, 16'h2048, KEY, 17'h060DE);
        step("wrong_key_zero", 16'h0000, 16'h0000, 32'h0, 17'h06E9E);
        step("key_restore", 16'h1111, 16'h2222, KEY, 17'h03333);

        for (int j = 0; j < 32; j++) begin
            for (int v = 0; v < 4; v++) begin
                a = 16'($urandom);
                b = 16'($urandom);
                k = KEY ^ (32'h1 << j);
                step("key_flip", a, b, k, model(a, b, k));
            end
        end

        for (int v = 0; v < 32; v++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            k = $urandom;
            step("rand_key", a, b, k, model(a, b, k));
        end

        for (int i = 0; i < 10000; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            step("rand_sum", a, b, KEY, {1'b0, a} + {1'b0, b});
        end

        step("pre_reset", 16'h1234, 16'h4321, KEY, 17'h05555);
        #2 rst_n = 1'b0;
        #1 check("midrun_reset", 17'h00000);
        @(posedge clk);
        #1 check("midrun_reset_hold", 17'h00000);
        @(negedge clk);
        rst_n = 1'b1;
        step("post_reset", 16'hABCD, 16'h1111, KEY, 17'h0BCDE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
